// File: rtl/five_arb.sv
// Two-requester round-robin arbiter that sequences one operation on a shared "five" unit.
// Latency: grant on the first rising edge that samples req!=0 in IDLE; done arrives
// max(len,1) drive cycles plus 1..TMO wait cycles later.
// Backpressure: requests are held off (not queued) while an operation is in flight;
// the shared unit stalls completion by holding status non-zero, bounded by TMO cycles.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          asynchronous active-high reset
//   req[1:0]       per-requester request, bit i = requester i
//   code0/code1    value each requester wants driven on sig
//   len0/len1      drive length in cycles (0 behaves as 1)
//   status[1:0]    shared unit status, 2'b00 = idle
//   sig[1:0]       value driven into the shared unit (non-zero only while driving)
//   gnt[1:0]       one-hot grant, held from DRIVE entry through the last WAIT cycle
//   busy           high whenever the FSM is not in IDLE
//   done           one-cycle completion pulse
//   done_id        index of the requester whose operation just finished
//   tmo_err        qualifies done: the operation ended by timeout
module five_arb #(
   parameter int unsigned TMO = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] code0,
   input  logic [1:0] code1,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   input  logic [1:0] status,
   output logic [1:0] sig,
   output logic [1:0] gnt,
   output logic       busy,
   output logic       done,
   output logic       done_id,
   output logic       tmo_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // The timeout counter starts at 0 on WAIT entry, so the last permitted WAIT
   // cycle is the one where it reads TMO-1.
   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   state_t     state_q, state_d;
   logic       win_q,   win_d;    // requester owning the current operation
   logic       ptr_q,   ptr_d;    // last winner, drives round-robin tie break
   logic [1:0] code_q,  code_d;
   logic [3:0] dcnt_q,  dcnt_d;   // remaining drive cycles, including the current one
   logic [7:0] tcnt_q,  tcnt_d;   // WAIT cycles already spent
   logic       tmo_q,   tmo_d;

   // Arbitration: on a tie the requester that did not win last time goes first;
   // a lone requester wins whatever the pointer says.
   logic       win_sel;
   logic [1:0] code_sel;
   logic [3:0] len_sel;

   always_comb begin
      win_sel = 1'b0;
      if (req == 2'b11) begin
         win_sel = ~ptr_q;
      end else begin
         win_sel = req[1];
      end
      code_sel = win_sel ? code1 : code0;
      len_sel  = win_sel ? len1  : len0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         win_q   <= 1'b0;
         ptr_q   <= 1'b1;
         code_q  <= 2'b00;
         dcnt_q  <= 4'd0;
         tcnt_q  <= 8'd0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         code_q  <= code_d;
         dcnt_q  <= dcnt_d;
         tcnt_q  <= tcnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      ptr_d   = ptr_q;
      code_d  = code_q;
      dcnt_d  = dcnt_q;
      tcnt_d  = tcnt_q;
      tmo_d   = tmo_q;

      unique case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               state_d = S_DRIVE;
               win_d   = win_sel;
               ptr_d   = win_sel;
               code_d  = code_sel;
               dcnt_d  = (len_sel == 4'd0) ? 4'd1 : len_sel;
               tmo_d   = 1'b0;
            end
         end
         S_DRIVE: begin
            if (dcnt_q == 4'd1) begin
               state_d = S_WAIT;
               tcnt_d  = 8'd0;
            end else begin
               dcnt_d  = dcnt_q - 4'd1;
            end
         end
         S_WAIT: begin
            // An idle status wins over the timeout when both occur on one edge.
            if (status == 2'b00) begin
               state_d = S_DONE;
               tmo_d   = 1'b0;
            end else if (tcnt_q == TMO_LAST) begin
               state_d = S_DONE;
               tmo_d   = 1'b1;
            end else begin
               tcnt_d  = tcnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode only registered state, so reset clears them without a clock.
   always_comb begin
      sig     = (state_q == S_DRIVE) ? code_q : 2'b00;
      gnt     = 2'b00;
      if ((state_q == S_DRIVE) || (state_q == S_WAIT)) begin
         gnt = win_q ? 2'b10 : 2'b01;
      end
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
      done_id = (state_q == S_DONE) & win_q;
      tmo_err = (state_q == S_DONE) & tmo_q;
   end

   a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
   a_sig_quiet:  assert property (@(posedge clk) disable iff (reset)
                                  (state_q != S_DRIVE) |-> (sig == 2'b00));

endmodule

// File: tb/tb_five_arb.sv
`timescale 1ns/1ps
module tb_five_arb;
   localparam int TMO = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req = 2'b00, code0 = 2'b00, code1 = 2'b00, status = 2'b00;
   logic [3:0] len0 = 4'd0, len1 = 4'd0;
   logic [1:0] sig, gnt;
   logic       busy, done, done_id, tmo_err;

   five_arb #(.TMO(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .code0(code0), .code1(code1),
      .len0(len0), .len1(len1), .status(status), .sig(sig), .gnt(gnt),
      .busy(busy), .done(done), .done_id(done_id), .tmo_err(tmo_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An operation is a timeline counted from its grant edge: cycles 0..D-1 drive,
   // then waiting until status is seen idle or TMO wait edges have elapsed, then
   // one done cycle, then at least one idle cycle.
   bit       m_active, m_donecyc, m_win, m_last, m_tmo;
   int       m_k, m_D;
   bit [1:0] m_code;
   int       m_len;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active = 0; m_donecyc = 0; m_win = 0; m_last = 1; m_tmo = 0; m_k = 0; m_D = 1;
      end else if (m_donecyc) begin
         m_donecyc = 0;
      end else if (m_active) begin
         if (m_k < m_D) begin
            m_k++;
         end else if (status == 2'b00 || (m_k - m_D + 1) >= TMO) begin
            m_active  = 0;
            m_donecyc = 1;
            m_tmo     = (status != 2'b00);
         end else begin
            m_k++;
         end
      end else if (req != 2'b00) begin
         m_win    = (req == 2'b11) ? !m_last : req[1];
         m_last   = m_win;
         m_active = 1;
         m_k      = 0;
         m_len    = m_win ? int'(len1) : int'(len0);
         m_D      = (m_len == 0) ? 1 : m_len;
         m_code   = m_win ? code1 : code0;
         m_tmo    = 0;
      end
   end

   bit         cmp_en = 0;
   logic [7:0] exp_v;
   always @(negedge clk) begin
      if (cmp_en && !reset) begin
         exp_v = {(m_active && m_k < m_D) ? m_code : 2'b00,
                  m_active ? (m_win ? 2'b10 : 2'b01) : 2'b00,
                  m_active | m_donecyc, m_donecyc, m_donecyc & m_win, m_donecyc & m_tmo};
         chk("cycle{sig,gnt,busy,done,id,tmo}", {sig, gnt, busy, done, done_id, tmo_err}, exp_v);
      end
   end

   // ---------------- directed helpers ----------------
   int         nd, nw;
   logic [1:0] og, os0;
   logic       odid, oterr;
   bit         ostable;

   // Observe one operation from the current negedge until done; optionally drop
   // status to idle during the drop_at-th WAIT cycle.
   task automatic run_op(input int drop_at, output int d, output int w, output logic [1:0] g,
                         output logic did, output logic terr, output logic [1:0] s0,
                         output bit stable);
      int cyc;
      cyc = 0; d = 0; w = 0; g = 0; did = 0; terr = 0; s0 = 0; stable = 1;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (gnt != 2'b00 && g == 2'b00) g = gnt;
         if (sig != 2'b00) begin
            if (d == 0) s0 = sig;
            else if (sig != s0) stable = 0;
            d++;
         end else if (gnt != 2'b00) begin
            w++;
            if (drop_at != 0 && w == drop_at) status = 2'b00;
         end
         if (done) begin
            did  = done_id;
            terr = tmo_err;
            break;
         end
         if (cyc > 300) begin
            checks++; errors++;
            $display("FAIL op_timeout: no done after %0d cycles, required within 300", cyc);
            break;
         end
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1;
      @(negedge clk); reset = 0;
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_outputs", {sig, gnt, busy, done, done_id, tmo_err}, 8'h00);
      reset = 0;
      cmp_en = 1;

      // single requester, len 3, status idle; grant on the first edge after release
      req = 2'b01; code0 = 2'd2; len0 = 4'd3; status = 2'b00;
      run_op(0, nd, nw, og, odid, oterr, os0, ostable);
      chk("basic_drive_cycles", 8'(nd), 8'd3);
      chk("basic_sig", 8'(os0), 8'd2);
      chk("basic_wait_cycles", 8'(nw), 8'd1);
      chk("basic_gnt", 8'(og), 8'h01);
      chk("basic_done_id", 8'(odid), 8'd0);
      chk("basic_tmo", 8'(oterr), 8'd0);
      req = 2'b00;
      @(negedge clk);
      chk("basic_busy_after", 8'(busy), 8'd0);

      // both requesting from reset: alternation 0,1,0,1
      pulse_reset();
      req = 2'b11; code0 = 2'd1; code1 = 2'd2; len0 = 4'd2; len1 = 4'd1;
      for (int i = 0; i < 4; i++) begin
         run_op(0, nd, nw, og, odid, oterr, os0, ostable);
         chk("rr_gnt", 8'(og), (i % 2 == 0) ? 8'h01 : 8'h02);
         chk("rr_done_id", 8'(odid), 8'(i % 2));
      end
      req = 2'b00;
      @(negedge clk);

      // len 0 behaves as a single drive cycle
      req = 2'b10; code1 = 2'd1; len1 = 4'd0;
      run_op(0, nd, nw, og, odid, oterr, os0, ostable);
      req = 2'b00;
      chk("len0_drive_cycles", 8'(nd), 8'd1);
      chk("len0_gnt", 8'(og), 8'h02);
      chk("len0_done_id", 8'(odid), 8'd1);
      @(negedge clk);

      // status stuck busy: timeout after TMO wait cycles
      req = 2'b01; code0 = 2'd3; len0 = 4'd1; status = 2'b10;
      run_op(0, nd, nw, og, odid, oterr, os0, ostable);
      req = 2'b00; status = 2'b00;
      chk("tmo_wait_cycles", 8'(nw), 8'd15);
      chk("tmo_err", 8'(oterr), 8'd1);
      @(negedge clk);

      // status clears exactly on the limit edge: normal exit wins
      req = 2'b01; status = 2'b10;
      run_op(15, nd, nw, og, odid, oterr, os0, ostable);
      req = 2'b00; status = 2'b00;
      chk("tmo_edge_wait_cycles", 8'(nw), 8'd15);
      chk("tmo_edge_err", 8'(oterr), 8'd0);
      @(negedge clk);

      // one cycle earlier as well
      req = 2'b01; status = 2'b11;
      run_op(14, nd, nw, og, odid, oterr, os0, ostable);
      req = 2'b00; status = 2'b00;
      chk("early_clear_wait_cycles", 8'(nw), 8'd14);
      chk("early_clear_err", 8'(oterr), 8'd0);
      @(negedge clk);

      // asynchronous reset in the middle of DRIVE (last winner was requester 0)
      req = 2'b01; code0 = 2'd2; len0 = 4'd5;
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("busy_before_rst", 8'(busy), 8'd1);
      reset = 1;
      #1;
      chk("async_rst_outputs", {sig, gnt, busy, done, done_id, tmo_err}, 8'h00);
      #2;
      reset = 0;
      req = 2'b11; code1 = 2'd1; len1 = 4'd2;
      run_op(0, nd, nw, og, odid, oterr, os0, ostable);
      req = 2'b00;
      chk("post_rst_gnt", 8'(og), 8'h01);
      chk("post_rst_drive_cycles", 8'(nd), 8'd5);
      @(negedge clk);

      // inputs changing after grant are ignored
      req = 2'b01; code0 = 2'd3; len0 = 4'd4; status = 2'b00;
      fork
         run_op(0, nd, nw, og, odid, oterr, os0, ostable);
         begin
            @(negedge clk); @(negedge clk);
            code0 = 2'd1; len0 = 4'd0; req = 2'b00;
         end
      join
      chk("ignore_drive_cycles", 8'(nd), 8'd4);
      chk("ignore_sig", 8'(os0), 8'd3);
      chk("ignore_sig_stable", 8'(ostable), 8'd1);
      chk("ignore_done_id", 8'(odid), 8'd0);
      @(negedge clk);

      // randomized traffic, checked every cycle against the model
      begin
         bit sticky;
         sticky = 0;
         for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (c % 200 == 0) sticky = ($urandom_range(0, 1) == 1);
            if (reset) reset = 0;
            else if ($urandom_range(0, 999) == 0) reset = 1;
            req   = 2'($urandom_range(0, 3));
            code0 = 2'($urandom_range(0, 3));
            code1 = 2'($urandom_range(0, 3));
            len0  = 4'($urandom_range(0, 15));
            len1  = 4'($urandom_range(0, 15));
            if (sticky) status = ($urandom_range(0, 99) < 3) ? 2'b00 : 2'($urandom_range(1, 3));
            else        status = ($urandom_range(0, 9) < 4) ? 2'b00 : 2'($urandom_range(1, 3));
         end
         reset = 0; req = 2'b00; status = 2'b00;
         repeat (40) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
